// File: rtl/cam_capture_ctrl_if.sv
// Camera pixel port, host register port and frame-buffer RAM port for cam_capture_ctrl.
// Handshakes: pix_valid and reg_wr/reg_rd are one-cycle strobes with no back-pressure; reg_rvalid pulses once per reg_rd.
interface cam_capture_ctrl_if #(
  parameter int ADDR_W = 18
);
  logic              pix_vsync;
  logic              pix_href;
  logic              pix_valid;
  logic [7:0]        pix_data;
  logic              reg_wr;
  logic              reg_rd;
  logic [7:0]        reg_addr;
  logic [7:0]        reg_wdata;
  logic [7:0]        reg_rdata;
  logic              reg_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  pix_vsync, pix_href, pix_valid, pix_data,
    input  reg_wr, reg_rd, reg_addr, reg_wdata,
    output reg_rdata, reg_rvalid,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output pix_vsync, pix_href, pix_valid, pix_data,
    output reg_wr, reg_rd, reg_addr, reg_wdata,
    input  reg_rdata, reg_rvalid,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/cam_capture_ctrl.sv
// Single-frame capture controller: grabs one VSYNC-bounded frame into the buffer RAM and
// streams it back to the host through an auto-incrementing DATA register.
module cam_capture_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int FRAME_BYTES = 153600
) (
  input  logic              clk,
  input  logic              reset,
  cam_capture_ctrl_if.slave bus,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_SYNC = 3'd2,
    S_CAPT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [7:0]        A_DATA    = 8'h00;
  localparam logic [7:0]        A_CTRL    = 8'h10;
  localparam logic [7:0]        A_STATUS  = 8'h14;
  localparam logic [7:0]        A_CNT0    = 8'h18;
  localparam logic [7:0]        A_CNT1    = 8'h19;
  localparam logic [7:0]        A_CNT2    = 8'h1A;
  localparam logic [23:0]       FRAME_CNT = 24'(FRAME_BYTES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t            state, state_nx;
  logic              vsync_q;
  logic              done, overflow;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [23:0]       count;
  logic              rd_pend, rd_iss_q, rd_cap_q;

  logic              vsync_rise, vsync_fall, busy;
  logic              ctrl_wr, start_cmd, abort_cmd;
  logic              pix_ok, cap_take, cap_wr, cap_ovf;
  logic              data_req, want_rd, rd_issue;
  logic              arm, set_done;
  logic [7:0]        rd_mux;
  logic              unused_wdata;

  assign state_dbg    = state;
  assign busy         = (state != S_IDLE);
  assign vsync_rise   = bus.pix_vsync & ~vsync_q;
  assign vsync_fall   = ~bus.pix_vsync & vsync_q;
  assign unused_wdata = ^bus.reg_wdata[7:2];

  // abort dominates start when both bits arrive in one write
  assign ctrl_wr   = bus.reg_wr && (bus.reg_addr == A_CTRL);
  assign start_cmd = ctrl_wr && bus.reg_wdata[0] && !bus.reg_wdata[1];
  assign abort_cmd = ctrl_wr && bus.reg_wdata[1];

  // an abort in the same cycle as a pixel suppresses that write
  assign pix_ok   = bus.pix_valid && bus.pix_href && !bus.pix_vsync;
  assign cap_take = (state == S_CAPT) && pix_ok && !abort_cmd;
  assign cap_wr   = cap_take && (count != FRAME_CNT);
  assign cap_ovf  = cap_take && (count == FRAME_CNT);

  // capture writes own the RAM port; a DATA read waits for the first free cycle
  assign data_req = bus.reg_rd && (bus.reg_addr == A_DATA);
  assign want_rd  = data_req || rd_pend;
  assign rd_issue = want_rd && !cap_wr;

  always_comb begin
    rd_mux = 8'h00;
    case (bus.reg_addr)
      A_STATUS: rd_mux = {5'b0, overflow, busy, done};
      A_CNT0:   rd_mux = count[7:0];
      A_CNT1:   rd_mux = count[15:8];
      A_CNT2:   rd_mux = count[23:16];
      default:  rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    state_nx = state;
    arm      = 1'b0;
    set_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_cmd) begin
          state_nx = S_ARM;
          arm      = 1'b1;
        end
      end
      S_ARM: begin
        if (abort_cmd)       state_nx = S_IDLE;
        else if (vsync_rise) state_nx = S_SYNC;
      end
      S_SYNC: begin
        if (abort_cmd)       state_nx = S_IDLE;
        else if (vsync_fall) state_nx = S_CAPT;
      end
      S_CAPT: begin
        if (abort_cmd)       state_nx = S_IDLE;
        else if (vsync_rise) state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
        set_done = !abort_cmd;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      vsync_q        <= 1'b0;
      done           <= 1'b0;
      overflow       <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      rd_pend        <= 1'b0;
      rd_iss_q       <= 1'b0;
      rd_cap_q       <= 1'b0;
      bus.reg_rdata  <= 8'h00;
      bus.reg_rvalid <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_we     <= 1'b0;
      bus.mem_wdata  <= 8'h00;
    end else begin
      state          <= state_nx;
      vsync_q        <= bus.pix_vsync;
      bus.mem_we     <= 1'b0;
      bus.reg_rvalid <= 1'b0;
      rd_pend        <= want_rd && cap_wr;
      rd_iss_q       <= rd_issue;
      rd_cap_q       <= rd_iss_q;

      if (arm) begin
        done     <= 1'b0;
        overflow <= 1'b0;
        wr_ptr   <= '0;
        count    <= '0;
      end

      if (cap_wr) begin
        bus.mem_we    <= 1'b1;
        bus.mem_addr  <= wr_ptr;
        bus.mem_wdata <= bus.pix_data;
        wr_ptr        <= wr_ptr + ADDR_ONE;
        count         <= count + 24'd1;
      end else if (rd_issue) begin
        bus.mem_addr <= rd_ptr;
        rd_ptr       <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ADDR_ONE;
      end

      if (cap_ovf) overflow <= 1'b1;

      if (set_done) begin
        done   <= 1'b1;
        rd_ptr <= '0;
      end

      // register reads answer next cycle; DATA answers once the RAM word is back
      if (bus.reg_rd && (bus.reg_addr != A_DATA)) begin
        bus.reg_rvalid <= 1'b1;
        bus.reg_rdata  <= rd_mux;
      end
      if (rd_cap_q) begin
        bus.reg_rvalid <= 1'b1;
        bus.reg_rdata  <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Scoreboard bench for cam_capture_ctrl: a full-size and a 16-byte instance share stimulus;
// the selected instance's read responses and RAM writes are checked against expected queues.
module tb_cam_capture_ctrl;
  localparam int ADDR_W     = 18;
  localparam int BIG_BYTES  = 153600;
  localparam int SMALL_BYTES = 16;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_ARM = 3'd1, ST_SYNC = 3'd2, ST_DONE = 3'd4;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cam_capture_ctrl_if #(.ADDR_W(ADDR_W)) bus_a ();
  cam_capture_ctrl_if #(.ADDR_W(ADDR_W)) bus_b ();
  logic [2:0] state_a, state_b;

  cam_capture_ctrl #(.ADDR_W(ADDR_W), .FRAME_BYTES(BIG_BYTES)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave), .state_dbg(state_a)
  );
  cam_capture_ctrl #(.ADDR_W(ADDR_W), .FRAME_BYTES(SMALL_BYTES)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave), .state_dbg(state_b)
  );

  assign bus_b.pix_vsync = bus_a.pix_vsync;
  assign bus_b.pix_href  = bus_a.pix_href;
  assign bus_b.pix_valid = bus_a.pix_valid;
  assign bus_b.pix_data  = bus_a.pix_data;
  assign bus_b.reg_wr    = bus_a.reg_wr;
  assign bus_b.reg_rd    = bus_a.reg_rd;
  assign bus_b.reg_addr  = bus_a.reg_addr;
  assign bus_b.reg_wdata = bus_a.reg_wdata;

  // RAM models: read data one cycle after the address
  logic [7:0] ram_a [256];
  logic [7:0] ram_b [256];
  function automatic logic [7:0] init_val(input int i);
    return 8'(i) ^ 8'h5A;
  endfunction
  initial for (int i = 0; i < 256; i++) begin
    ram_a[i] = init_val(i);
    ram_b[i] = init_val(i);
  end
  always @(posedge clk) begin
    if (bus_a.mem_we) ram_a[bus_a.mem_addr[7:0]] <= bus_a.mem_wdata;
    else              bus_a.mem_rdata <= ram_a[bus_a.mem_addr[7:0]];
    if (bus_b.mem_we) ram_b[bus_b.mem_addr[7:0]] <= bus_b.mem_wdata;
    else              bus_b.mem_rdata <= ram_b[bus_b.mem_addr[7:0]];
  end

  // observed instance
  logic              sel;
  logic              m_rvalid, m_we;
  logic [7:0]        m_rdata, m_wdata;
  logic [ADDR_W-1:0] m_addr;
  logic [2:0]        m_state;
  always_comb begin
    m_rvalid = sel ? bus_b.reg_rvalid : bus_a.reg_rvalid;
    m_rdata  = sel ? bus_b.reg_rdata  : bus_a.reg_rdata;
    m_we     = sel ? bus_b.mem_we     : bus_a.mem_we;
    m_wdata  = sel ? bus_b.mem_wdata  : bus_a.mem_wdata;
    m_addr   = sel ? bus_b.mem_addr   : bus_a.mem_addr;
    m_state  = sel ? state_b          : state_a;
  end

  // scoreboard
  logic [7:0]          exp_q[$];
  int                  exp_cyc_q[$];
  logic [ADDR_W+7:0]   wexp_q[$];
  int                  wcyc_q[$];
  logic [7:0]          mdl [256];
  int                  rp;
  int                  total = 0;
  int                  bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (m_rvalid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rvalid: got rdata %0h want no response (cycle %0d)", m_rdata, cyc);
      end else begin
        check("rdata", m_rdata, exp_q.pop_front());
        check("rvalid_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
    if (m_we) begin
      if (wexp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h want no write (cycle %0d)", m_addr, m_wdata, cyc);
      end else begin
        check("write_addr_data", {m_addr, m_wdata}, wexp_q.pop_front());
        check("write_cycle", cyc, wcyc_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_reads();
    for (int i = 0; i < 16 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL read_timeout: got %0d responses outstanding want 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic reg_write(input logic [7:0] addr, input logic [7:0] data);
    bus_a.reg_wr    = 1'b1;
    bus_a.reg_addr  = addr;
    bus_a.reg_wdata = data;
    tick();
    bus_a.reg_wr    = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] addr, input logic [7:0] exp, input int lat);
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + lat);
    bus_a.reg_rd   = 1'b1;
    bus_a.reg_addr = addr;
    tick();
    bus_a.reg_rd   = 1'b0;
    wait_reads();
  endtask

  task automatic data_read(input logic [7:0] exp);
    reg_read(8'h00, exp, 3);
    rp++;
  endtask

  task automatic pixel(input logic [7:0] data, input int k, input int lim);
    bus_a.pix_valid = 1'b1;
    bus_a.pix_data  = data;
    if (k < lim) begin
      wexp_q.push_back({ADDR_W'(k), data});
      wcyc_q.push_back(cyc + 1);
      if (!sel) mdl[k] = data;
    end
  endtask

  // one VSYNC-bounded frame; contend_at issues a DATA read alongside that byte
  task automatic send_frame(input int lines, input int per_line, input int base,
                            input int contend_at, input int lim, input logic completes);
    int k;
    k = 0;
    bus_a.pix_vsync = 1'b1;
    repeat (3) tick();
    bus_a.pix_vsync = 1'b0;
    repeat (3) tick();
    for (int l = 0; l < lines; l++) begin
      bus_a.pix_href = 1'b1;
      tick();
      for (int b = 0; b < per_line; b++) begin
        pixel(8'(base + k), k, lim);
        if (k == contend_at) begin
          exp_q.push_back(mdl[rp]);
          exp_cyc_q.push_back(cyc + 4);
          rp++;
          bus_a.reg_rd   = 1'b1;
          bus_a.reg_addr = 8'h00;
        end
        tick();
        bus_a.pix_valid = 1'b0;
        bus_a.reg_rd    = 1'b0;
        tick();
        k++;
      end
      bus_a.pix_href = 1'b0;
      repeat (2) tick();
    end
    bus_a.pix_vsync = 1'b1;
    tick();
    if (completes) begin
      check("frame_end_done_state", m_state, ST_DONE);
      tick();
      check("frame_end_idle_state", m_state, ST_IDLE);
      rp = 0;
    end else begin
      tick();
    end
    tick();
    bus_a.pix_vsync = 1'b0;
    tick();
    wait_reads();
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_rdata"},  m_rdata,  0);
    check({tag, "_rvalid"}, m_rvalid, 0);
    check({tag, "_maddr"},  m_addr,   0);
    check({tag, "_mwe"},    m_we,     0);
    check({tag, "_mwdata"}, m_wdata,  0);
    check({tag, "_state"},  m_state,  ST_IDLE);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish by 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    sel             = 1'b0;
    reset           = 1'b1;
    rp              = 0;
    bus_a.pix_vsync = 1'b0;
    bus_a.pix_href  = 1'b0;
    bus_a.pix_valid = 1'b0;
    bus_a.pix_data  = 8'h00;
    bus_a.reg_wr    = 1'b0;
    bus_a.reg_rd    = 1'b0;
    bus_a.reg_addr  = 8'h00;
    bus_a.reg_wdata = 8'h00;
    for (int i = 0; i < 256; i++) mdl[i] = init_val(i);
    repeat (3) tick();
    check_outputs_reset("reset");
    reset = 1'b0;
    tick();

    // idle reads: STATUS, DATA latency and pointer advance, unmapped
    reg_read(8'h14, 8'h00, 1);
    data_read(init_val(0));
    data_read(init_val(1));
    reg_read(8'h33, 8'h00, 1);
    reg_read(8'h10, 8'h00, 1);

    // 4x8 frame, values 0..31
    reg_write(8'h10, 8'h01);
    check("start_arm_state", m_state, ST_ARM);
    send_frame(4, 8, 0, -1, BIG_BYTES, 1'b1);
    reg_read(8'h14, 8'h01, 1);
    reg_read(8'h18, 8'h20, 1);
    reg_read(8'h19, 8'h00, 1);
    reg_read(8'h1A, 8'h00, 1);
    for (int i = 0; i < 32; i++) data_read(8'(i));

    // abort while in SYNC, then start+abort together while idle
    reg_write(8'h10, 8'h01);
    bus_a.pix_vsync = 1'b1;
    repeat (2) tick();
    check("abort_pre_sync_state", m_state, ST_SYNC);
    reg_read(8'h14, 8'h02, 1);
    reg_write(8'h10, 8'h02);
    check("abort_idle_state", m_state, ST_IDLE);
    send_frame(1, 8, 50, -1, 0, 1'b0);
    reg_read(8'h14, 8'h00, 1);
    reg_write(8'h10, 8'h03);
    check("start_abort_idle_state", m_state, ST_IDLE);
    reg_read(8'h14, 8'h00, 1);

    // reset after 5 captured bytes
    reg_write(8'h10, 8'h01);
    bus_a.pix_vsync = 1'b1;
    repeat (3) tick();
    bus_a.pix_vsync = 1'b0;
    repeat (3) tick();
    bus_a.pix_href = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      pixel(8'(200 + k), k, BIG_BYTES);
      tick();
      bus_a.pix_valid = 1'b0;
      tick();
    end
    reset = 1'b1;
    tick();
    check_outputs_reset("midreset");
    reset = 1'b0;
    bus_a.pix_href = 1'b0;
    rp = 0;
    tick();
    reg_read(8'h14, 8'h00, 1);

    // full frame after reset with a DATA read colliding with byte 3
    reg_write(8'h10, 8'h01);
    send_frame(4, 8, 100, 3, BIG_BYTES, 1'b1);
    reg_read(8'h14, 8'h01, 1);
    reg_read(8'h18, 8'h20, 1);
    for (int i = 0; i < 32; i++) data_read(8'(100 + i));

    // 16-byte buffer: 20 bytes overflow, read pointer wraps
    sel   = 1'b1;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    rp    = 0;
    tick();
    reg_write(8'h10, 8'h01);
    send_frame(4, 5, 0, -1, SMALL_BYTES, 1'b1);
    reg_read(8'h14, 8'h05, 1);
    reg_read(8'h18, 8'h10, 1);
    reg_read(8'h19, 8'h00, 1);
    for (int i = 0; i < 16; i++) data_read(8'(i));
    data_read(8'h00);

    repeat (4) tick();
    check("writes_left", wexp_q.size(), 0);
    check("reads_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
